// File: rtl/pkg_graybin.sv
// Shared definitions for the FIFO family: default geometry, the counter
// width helper and the read-mode selector used by the synchronous FIFO.
package pkg_graybin;

    // Default data width and depth for FIFO instances in this family.
    localparam int DEF_DATASIZE = 8;
    localparam int DEF_DEPTH    = 16;

    // Read-mode selector for fifo_sync_fwft.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointer/count width: address bits plus one wrap bit, so that a
    // count of exactly DEPTH is representable.
    function automatic int cntw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Storage array for the synchronous FIFO: one clocked write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_sync_ram #(
    parameter int DATASIZE = 8,
    parameter int DEPTH    = 16
) (
    input  logic                      clk,
    input  logic                      wen,
    input  logic [$clog2(DEPTH)-1:0]  waddr,
    input  logic [DATASIZE-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0]  raddr,
    output logic [DATASIZE-1:0]       rdata
);

    logic [DATASIZE-1:0] mem [DEPTH];

    // Write port: store the accepted word at the write address.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read of the head entry; FWFT mode presents it directly.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags and an optional
// first-word-fall-through read mode. Flags and count are registered and
// derived from the next-state pointers so they always agree with o_count.
module fifo_sync_fwft
    import pkg_graybin::*;
#(
    parameter int         DATASIZE   = DEF_DATASIZE,
    parameter int         DEPTH      = DEF_DEPTH,
    parameter int         AFULL_THR  = DEPTH - 2,
    parameter int         AEMPTY_THR = 2,
    parameter fifo_mode_e FWFT       = FIFO_STD
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [DATASIZE-1:0]         i_data,
    input  logic                        i_wren,
    input  logic                        i_rden,
    input  logic                        i_clr_err,
    output logic [DATASIZE-1:0]         o_data,
    output logic                        o_wr_full,
    output logic                        o_rd_empty,
    output logic                        o_afull,
    output logic                        o_aempty,
    output logic [cntw(DEPTH)-1:0]      o_count,
    output logic                        o_overflow,
    output logic                        o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cntw(DEPTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

    // Elaboration-time parameter checks.
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_sync_fwft: DEPTH must be a power of two and at least 4");
    end
    if ((AFULL_THR < 1) || (AFULL_THR > DEPTH)) begin : g_bad_afull
        $error("fifo_sync_fwft: AFULL_THR must lie in 1..DEPTH");
    end
    if ((AEMPTY_THR < 0) || (AEMPTY_THR > DEPTH - 1)) begin : g_bad_aempty
        $error("fifo_sync_fwft: AEMPTY_THR must lie in 0..DEPTH-1");
    end

    logic [CW-1:0]       wptr;
    logic [CW-1:0]       rptr;
    logic [CW-1:0]       wptr_nxt;
    logic [CW-1:0]       rptr_nxt;
    logic [CW-1:0]       count_nxt;
    logic                wr_ok;
    logic                rd_ok;
    logic                wr_err;
    logic                rd_err;
    logic [DATASIZE-1:0] rdata;
    logic [DATASIZE-1:0] data_q;

    // Accept decisions from the registered flags, and next-state pointers.
    // A write while full is dropped even if a read frees a slot this cycle;
    // likewise a read while empty is dropped even alongside a write.
    always_comb begin
        wr_ok     = i_wren & ~o_wr_full;
        rd_ok     = i_rden & ~o_rd_empty;
        wr_err    = i_wren & o_wr_full;
        rd_err    = i_rden & o_rd_empty;
        wptr_nxt  = wptr + CW'(wr_ok);
        rptr_nxt  = rptr + CW'(rd_ok);
        // Modulo-2^CW difference; the wrap bit separates full from empty.
        count_nxt = wptr_nxt - rptr_nxt;
    end

    // Pointers, count and status flags, all from the next-state count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            o_count    <= '0;
            o_wr_full  <= 1'b0;
            o_rd_empty <= 1'b1;
            o_afull    <= (AFULL_THR == 0);
            o_aempty   <= 1'b1;
        end else begin
            wptr       <= wptr_nxt;
            rptr       <= rptr_nxt;
            o_count    <= count_nxt;
            o_wr_full  <= (count_nxt == DEPTH_C);
            o_rd_empty <= (count_nxt == '0);
            o_afull    <= (count_nxt >= AFULL_C);
            o_aempty   <= (count_nxt <= AEMPTY_C);
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= (o_overflow  & ~i_clr_err) | wr_err;
            o_underflow <= (o_underflow & ~i_clr_err) | rd_err;
        end
    end

    // Standard-mode output register: loads the head word on an accepted
    // read and holds otherwise, including on underflow attempts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= '0;
        end else if (rd_ok) begin
            data_q <= rdata;
        end
    end

    // FWFT presents the head entry combinationally; standard mode the register.
    assign o_data = (FWFT == FIFO_FWFT) ? rdata : data_q;

    fifo_sync_ram #(
        .DATASIZE (DATASIZE),
        .DEPTH    (DEPTH)
    ) u_ram (
        .clk   (i_clk),
        .wen   (wr_ok),
        .waddr (wptr[AW-1:0]),
        .wdata (i_data),
        .raddr (rptr[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Directed bench for fifo_sync_fwft: one standard-mode and one FWFT-mode
// instance driven by identical stimulus (DEPTH=8, AFULL_THR=6, AEMPTY_THR=2).
module tb_fifo_sync_fwft;
    import pkg_graybin::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       wren;
    logic       rden;
    logic       clr_err;

    logic [7:0] s_data, f_data;
    logic       s_full, f_full, s_empty, f_empty;
    logic       s_afull, f_afull, s_aempty, f_aempty;
    logic [3:0] s_count, f_count;
    logic       s_ovf, f_ovf, s_unf, f_unf;

    int checks   = 0;
    int failures = 0;

    fifo_sync_fwft #(.DATASIZE(8), .DEPTH(8), .AFULL_THR(6), .AEMPTY_THR(2), .FWFT(FIFO_STD)) u_std (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_wren(wren), .i_rden(rden),
        .i_clr_err(clr_err), .o_data(s_data), .o_wr_full(s_full), .o_rd_empty(s_empty),
        .o_afull(s_afull), .o_aempty(s_aempty), .o_count(s_count),
        .o_overflow(s_ovf), .o_underflow(s_unf)
    );

    fifo_sync_fwft #(.DATASIZE(8), .DEPTH(8), .AFULL_THR(6), .AEMPTY_THR(2), .FWFT(FIFO_FWFT)) u_fwft (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_wren(wren), .i_rden(rden),
        .i_clr_err(clr_err), .o_data(f_data), .o_wr_full(f_full), .o_rd_empty(f_empty),
        .o_afull(f_afull), .o_aempty(f_aempty), .o_count(f_count),
        .o_overflow(f_ovf), .o_underflow(f_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rden = 1'b1; step(); rden = 1'b0;
        wren = 1'b1; din = 8'h33; step(); step(); wren = 1'b0;
        checks++; if (s_count !== 4'd2) begin failures++; $display("FAIL pre_reset_count got=%0d exp=2", s_count); end
        checks++; if (s_unf !== 1'b1) begin failures++; $display("FAIL pre_reset_unf got=%b exp=1", s_unf); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (s_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", s_empty); end
        checks++; if (s_count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", s_count); end
        checks++; if (s_aempty !== 1'b1) begin failures++; $display("FAIL rst_aempty got=%b exp=1", s_aempty); end
        checks++; if (s_full !== 1'b0 || s_afull !== 1'b0) begin failures++; $display("FAIL rst_full_afull got=%b%b exp=00", s_full, s_afull); end
        checks++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin failures++; $display("FAIL rst_err got=%b%b exp=00", s_ovf, s_unf); end
        checks++; if (s_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", s_data); end
        checks++; if (f_empty !== 1'b1 || f_count !== 4'd0) begin failures++; $display("FAIL rst_fwft got=%b/%0d exp=1/0", f_empty, f_count); end
        #2 rst_n = 1'b1;
        step();
        checks++; if (s_empty !== 1'b1 || s_count !== 4'd0) begin failures++; $display("FAIL post_rst got=%b/%0d exp=1/0", s_empty, s_count); end
    endtask

    task automatic test_fill_drain_std();
        for (int i = 0; i < 8; i++) begin
            wren = 1'b1; din = 8'h10 + 8'(i); step();
            checks++; if (s_count !== 4'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, s_count, i + 1); end
            checks++; if (s_afull !== (i + 1 >= 6)) begin failures++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, s_afull, (i + 1 >= 6)); end
            checks++; if (s_aempty !== (i + 1 <= 2)) begin failures++; $display("FAIL fill_aempty[%0d] got=%b exp=%b", i, s_aempty, (i + 1 <= 2)); end
            checks++; if (s_full !== (i == 7)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, s_full, (i == 7)); end
        end
        din = 8'hFF; step(); wren = 1'b0;
        checks++; if (s_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", s_ovf); end
        checks++; if (s_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", s_count); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (f_data !== 8'h10 + 8'(i)) begin failures++; $display("FAIL fwft_head[%0d] got=%h exp=%h", i, f_data, 8'h10 + 8'(i)); end
            rden = 1'b1; step();
            checks++; if (s_data !== 8'h10 + 8'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, s_data, 8'h10 + 8'(i)); end
            checks++; if (s_count !== 4'(7 - i)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, s_count, 7 - i); end
        end
        rden = 1'b0;
        checks++; if (s_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", s_empty); end
        clr_err = 1'b1; step(); clr_err = 1'b0;
        checks++; if (s_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", s_ovf); end
        checks++; if (s_data !== 8'h17) begin failures++; $display("FAIL data_hold got=%h exp=17", s_data); end
    endtask

    task automatic test_fwft();
        wren = 1'b1; din = 8'hA5; step(); wren = 1'b0;
        checks++; if (f_data !== 8'hA5) begin failures++; $display("FAIL fwft_data got=%h exp=a5", f_data); end
        checks++; if (f_empty !== 1'b0) begin failures++; $display("FAIL fwft_nonempty got=%b exp=0", f_empty); end
        checks++; if (s_data !== 8'h17) begin failures++; $display("FAIL std_no_read got=%h exp=17", s_data); end
        step();
        checks++; if (f_data !== 8'hA5) begin failures++; $display("FAIL fwft_hold got=%h exp=a5", f_data); end
        rden = 1'b1; step(); rden = 1'b0;
        checks++; if (f_empty !== 1'b1 || f_count !== 4'd0) begin failures++; $display("FAIL fwft_pop got=%b/%0d exp=1/0", f_empty, f_count); end
        checks++; if (s_data !== 8'hA5) begin failures++; $display("FAIL std_pop_data got=%h exp=a5", s_data); end
    endtask

    task automatic test_simultaneous();
        wren = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 8'h20 + 8'(i); step();
        end
        checks++; if (s_full !== 1'b1) begin failures++; $display("FAIL sim_full got=%b exp=1", s_full); end
        din = 8'h55; rden = 1'b1; step(); wren = 1'b0; rden = 1'b0;
        checks++; if (s_data !== 8'h20) begin failures++; $display("FAIL sim_full_data got=%h exp=20", s_data); end
        checks++; if (s_count !== 4'd7) begin failures++; $display("FAIL sim_full_count got=%0d exp=7", s_count); end
        checks++; if (s_ovf !== 1'b1 || s_full !== 1'b0) begin failures++; $display("FAIL sim_full_flags got=%b%b exp=10", s_ovf, s_full); end
        clr_err = 1'b1; step(); clr_err = 1'b0;
        rden = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (s_data !== 8'h21 + 8'(i)) begin failures++; $display("FAIL sim_read[%0d] got=%h exp=%h", i, s_data, 8'h21 + 8'(i)); end
        end
        wren = 1'b1; din = 8'h66; step(); wren = 1'b0; rden = 1'b0;
        checks++; if (s_count !== 4'd4) begin failures++; $display("FAIL sim_mid_count got=%0d exp=4", s_count); end
        checks++; if (s_data !== 8'h24) begin failures++; $display("FAIL sim_mid_data got=%h exp=24", s_data); end
        checks++; if ({s_full, s_empty, s_afull, s_aempty, s_ovf} !== 5'b0) begin failures++; $display("FAIL sim_mid_flags got=%b exp=00000", {s_full, s_empty, s_afull, s_aempty, s_ovf}); end
        rden = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (s_data !== ((i < 3) ? 8'h25 + 8'(i) : 8'h66)) begin failures++; $display("FAIL sim_drain[%0d] got=%h exp=%h", i, s_data, ((i < 3) ? 8'h25 + 8'(i) : 8'h66)); end
        end
        rden = 1'b0;
        checks++; if (s_empty !== 1'b1) begin failures++; $display("FAIL sim_drain_empty got=%b exp=1", s_empty); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            wren = 1'b1; din = 8'h40 + 8'(i); step(); wren = 1'b0;
            checks++; if (f_data !== 8'h40 + 8'(i) || f_count !== 4'd1) begin failures++; $display("FAIL wrap_wr[%0d] got=%h/%0d exp=%h/1", i, f_data, f_count, 8'h40 + 8'(i)); end
            rden = 1'b1; step(); rden = 1'b0;
            checks++; if (s_data !== 8'h40 + 8'(i) || s_count !== 4'd0) begin failures++; $display("FAIL wrap_rd[%0d] got=%h/%0d exp=%h/0", i, s_data, s_count, 8'h40 + 8'(i)); end
        end
    endtask

    task automatic test_errors();
        rden = 1'b1; step(); rden = 1'b0;
        checks++; if (s_unf !== 1'b1) begin failures++; $display("FAIL unf_set got=%b exp=1", s_unf); end
        checks++; if (s_data !== 8'h53 || s_count !== 4'd0) begin failures++; $display("FAIL unf_hold got=%h/%0d exp=53/0", s_data, s_count); end
        clr_err = 1'b1; step(); clr_err = 1'b0;
        checks++; if (s_unf !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", s_unf); end
        clr_err = 1'b1; rden = 1'b1; step(); clr_err = 1'b0; rden = 1'b0;
        checks++; if (s_unf !== 1'b1) begin failures++; $display("FAIL unf_set_wins got=%b exp=1", s_unf); end
        step();
        checks++; if (s_unf !== 1'b1 || s_ovf !== 1'b0) begin failures++; $display("FAIL unf_sticky got=%b%b exp=10", s_unf, s_ovf); end
    endtask

    initial begin
        rst_n = 1'b0; din = 8'h00; wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        test_reset();
        test_fill_drain_std();
        test_fwft();
        test_simultaneous();
        test_wrap();
        test_errors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
